// File: rtl/acc_sequencer.sv
// Accumulator operand/writeback sequencer around an external 9-bit ALU.
// Accepts one command at a time, drives the ALU for one cycle, retires on DONE.
module acc_sequencer #(
    parameter int WIDTH = 9
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [2:0]       CMD_OP,
    input  logic [WIDTH-1:0] CMD_DATA,
    output logic [1:0]       ALU_SEL,
    output logic [WIDTH-1:0] ALU_AC,
    output logic [WIDTH-1:0] ALU_DR,
    input  logic [WIDTH-1:0] ALU_OUT,
    input  logic             ALU_CARRY,
    output logic [WIDTH-1:0] AC_OUT,
    output logic             C_FLAG,
    output logic             Z_FLAG,
    output logic             DONE,
    output logic             ERR
);

    localparam logic [2:0] OP_LDAC = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_CLAC = 3'b100;
    localparam logic [2:0] OP_INAC = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       op;
    logic [WIDTH-1:0] ac;
    logic [WIDTH-1:0] dr;
    logic [1:0]       sel;
    logic             rdy;
    logic             c;
    logic             z;
    logic             done;
    logic             err;

    logic [WIDTH-1:0] ac_nxt;
    logic             c_nxt;
    logic             bad_op;

    function automatic logic [1:0] sel_of(input logic [2:0] o);
        logic [1:0] s;
        s = 2'b10;
        unique case (1'b1)
            (o == OP_ADD),
            (o == OP_INAC): s = 2'b00;
            (o == OP_SUB):  s = 2'b01;
            default:        s = 2'b10;
        endcase
        return s;
    endfunction

    // Result selection for the edge that ends EXEC.
    always_comb begin
        ac_nxt = ac;
        c_nxt  = c;
        bad_op = 1'b0;
        unique case (1'b1)
            (op == OP_ADD),
            (op == OP_SUB),
            (op == OP_INAC): begin
                ac_nxt = ALU_OUT;
                c_nxt  = ALU_CARRY;
            end
            (op == OP_AND):  ac_nxt = ALU_OUT;
            (op == OP_LDAC): ac_nxt = dr;
            (op == OP_CLAC): begin
                ac_nxt = '0;
                c_nxt  = 1'b0;
            end
            default:         bad_op = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            op    <= '0;
            ac    <= '0;
            dr    <= '0;
            sel   <= 2'b00;
            rdy   <= 1'b1;
            c     <= 1'b0;
            z     <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (CMD_VALID && rdy) begin
                        op  <= CMD_OP;
                        sel <= sel_of(CMD_OP);
                        rdy <= 1'b0;
                        unique case (1'b1)
                            (CMD_OP == OP_LDAC),
                            (CMD_OP == OP_ADD),
                            (CMD_OP == OP_SUB),
                            (CMD_OP == OP_AND):
                                dr <= CMD_DATA;
                            (CMD_OP == OP_INAC):
                                dr <= WIDTH'(1);
                            (CMD_OP == OP_CLAC):
                                dr <= '0;
                            default: ;
                        endcase
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    ac    <= ac_nxt;
                    c     <= c_nxt;
                    z     <= (ac_nxt == '0);
                    err   <= err | bad_op;
                    done  <= 1'b1;
                    state <= WB;
                end
                WB: begin
                    done  <= 1'b0;
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign CMD_READY = rdy;
    assign ALU_SEL   = sel;
    assign ALU_AC    = ac;
    assign ALU_DR    = dr;
    assign AC_OUT    = ac;
    assign C_FLAG    = c;
    assign Z_FLAG    = z;
    assign DONE      = done;
    assign ERR       = err;

endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
- Operand/writeback stage wrapped around the 9-bit ALU (ADD/SUB/AND, SEL 00/01/10).
- Accepts accumulator commands from the control unit over a valid/ready handshake and latches the memory operand into DR.
- Drives the ALU's SEL/AC/DR inputs, then captures the ALU result and carry back into AC with C and Z flags.
- One command is in flight at a time.

Parameters:
- WIDTH, 9, datapath width of AC, DR and ALU operands/result.

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST_N  input  1  synchronous active-low reset, sampled on rising CLK
- CMD_VALID  input  1  command present
- CMD_READY  output  1  sequencer can accept a command
- CMD_OP  input  3  000 LDAC, 001 ADD, 010 SUB, 011 AND, 100 CLAC, 101 INAC, 110/111 illegal
- CMD_DATA  input  WIDTH  memory operand (ignored by CLAC, INAC, illegal ops)
- ALU_SEL  output  2  to ALU SEL
- ALU_AC  output  WIDTH  to ALU AC (mirrors AC register)
- ALU_DR  output  WIDTH  to ALU DR (mirrors DR register)
- ALU_OUT  input  WIDTH  ALU result
- ALU_CARRY  input  1  ALU bit WIDTH (carry for ADD, borrow for SUB, 0 for AND)
- AC_OUT  output  WIDTH  accumulator value
- C_FLAG  output  1  carry/borrow of last arithmetic op
- Z_FLAG  output  1  AC == 0
- DONE  output  1  one-cycle pulse: command retired, AC/flags updated
- ERR  output  1  sticky illegal-opcode flag

Behaviour:
- Reset (RST_N=0 at a rising edge, any state, including mid-command):
  - state IDLE; AC=0, DR=0, latched op=0, C_FLAG=0, Z_FLAG=1, ERR=0, DONE=0, ALU_SEL=00.
  - The in-flight command is discarded, with no DONE pulse.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - CMD_READY=1.
  - On CMD_VALID&CMD_READY: latch CMD_OP. Load DR per op: LDAC/ADD/SUB/AND DR<=CMD_DATA; INAC DR<=1; CLAC DR<=0; illegal DR unchanged.
  - Go to EXEC.
- EXEC:
  - CMD_READY=0.
  - ALU_SEL per latched op: ADD/INAC 00, SUB 01, AND 10, LDAC/CLAC/illegal 10 (don't-care, held at 10).
  - ALU inputs are stable for the whole cycle.
  - At the edge ending EXEC:
    - ADD/SUB/INAC: AC<=ALU_OUT, C_FLAG<=ALU_CARRY.
    - AND: AC<=ALU_OUT, C_FLAG unchanged.
    - LDAC: AC<=DR, C unchanged.
    - CLAC: AC<=0, C<=0.
    - Illegal: AC and C unchanged, ERR<=1.
  - Go to WB.
- WB:
  - CMD_READY=0, DONE=1 for exactly this cycle.
  - Z_FLAG reflects the new AC (registered together with AC at the end of EXEC).
  - Go to IDLE.
- Latency: accept edge to DONE high = 2 cycles. Throughput: one command per 3 cycles.
- Arithmetic: modulo 2^WIDTH.
  - SUB borrow: C=1 when AC<DR unsigned.
  - INAC of 0x1FF gives AC=0, C=1, Z=1.
- CMD_VALID held in EXEC/WB is ignored, not consumed. CMD_OP and CMD_DATA only need to be stable in the accept cycle.
- ERR clears only on reset.
- AC_OUT = ALU_AC = AC register at all times.

Test Plan:
- Reset then LDAC 0x0A5 -> CMD_READY low for 2 cycles, DONE in cycle 2 after accept; AC_OUT=0x0A5, Z=0, C=0.
- AC=0x1F0, ADD 0x020 -> ALU_SEL=00 during EXEC, AC=0x010, C=1, Z=0.
- AC=0x005, SUB 0x006 -> SEL=01, AC=0x1FF, C=1. Then AND 0x000 -> AC=0, Z=1, C still 1.
- AC=0x1FF, INAC -> AC=0, C=1, Z=1. Then CLAC -> AC=0, C=0, Z=1.
- CMD_OP=111 with AC=0x033 -> DONE pulses, AC=0x033 unchanged, ERR=1 and remains set across later valid commands.
- CMD_VALID held high continuously with ADD 0x001 from AC=0 -> exactly one accept per 3 cycles, AC increments 1,2,3.
- RST_N low during EXEC -> next cycle IDLE, AC=0, Z=1, no DONE pulse.
